// File: rtl/gpu_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction BlockRam read port
// and hands fetched words to decode over a valid/ready handshake.
module gpu_fetch #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned WORD_WIDTH    = 32,
    parameter logic [31:0] RESET_PC      = 32'h0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     run,
    output logic [ADDRESS_WIDTH-1:0] inst_ram_address,
    input  logic [WORD_WIDTH-1:0]    inst_ram_read_data,
    output logic [WORD_WIDTH-1:0]    insn_out,
    output logic [31:0]              pc_out,
    output logic                     insn_valid,
    input  logic                     insn_ready,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [31:0]              fetch_count
);

    localparam int unsigned PC_WORD_WIDTH = 30;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        FETCHED = 2'd2,
        VALID   = 2'd3
    } state_t;

    state_t                   state;
    // PC held as a word address; the byte-offset bits are always zero.
    logic [PC_WORD_WIDTH-1:0] pc_word;

    // Misaligned redirect bits are dropped by design.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign inst_ram_address = pc_word[ADDRESS_WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            pc_word     <= RESET_PC[31:2];
            insn_valid  <= 1'b0;
            insn_out    <= '0;
            pc_out      <= '0;
            fetch_count <= '0;
        end else if (redirect) begin
            // Redirect discards anything in flight or held, without counting it.
            pc_word    <= redirect_pc[31:2];
            insn_valid <= 1'b0;
            state      <= run ? ISSUE : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= FETCHED;
                end
                FETCHED: begin
                    insn_out   <= inst_ram_read_data;
                    pc_out     <= {pc_word, 2'b00};
                    insn_valid <= 1'b1;
                    state      <= VALID;
                end
                VALID: begin
                    if (insn_ready) begin
                        pc_word     <= pc_word + PC_WORD_WIDTH'(1);
                        fetch_count <= fetch_count + 32'd1;
                        insn_valid  <= 1'b0;
                        state       <= run ? ISSUE : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_fetch.sv
// Directed bench for gpu_fetch: transaction-level model checked every cycle,
// plus hand-computed expectations along the test plan.
module tb_gpu_fetch;

    localparam int unsigned AW = 16;
    localparam int unsigned WW = 32;
    localparam logic [31:0] RPC = 32'h0;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b1;
    logic [AW-1:0] inst_ram_address;
    logic [WW-1:0] inst_ram_read_data;
    logic [WW-1:0] insn_out;
    logic [31:0]   pc_out;
    logic          insn_valid;
    logic          insn_ready = 1'b1;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic [31:0]   fetch_count;

    int nvec = 0;
    int nerr = 0;

    logic [WW-1:0] mem [0:(1<<AW)-1];

    gpu_fetch #(.ADDRESS_WIDTH(AW), .WORD_WIDTH(WW), .RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset), .run(run),
        .inst_ram_address(inst_ram_address),
        .inst_ram_read_data(inst_ram_read_data),
        .insn_out(insn_out), .pc_out(pc_out), .insn_valid(insn_valid),
        .insn_ready(insn_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    // BlockRam with registered read
    always @(posedge clock) inst_ram_read_data <= mem[inst_ram_address];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a launched fetch produces a valid word two edges later.
    logic        m_on = 1'b0;
    logic [31:0] m_pc, m_pcout, m_insn, m_cnt;
    logic        m_valid, m_idle;
    int          m_wait;

    always @(posedge clock) begin
        if (reset) begin
            m_on = 1'b1; m_pc = RPC & ~32'h3; m_valid = 1'b0; m_insn = '0;
            m_pcout = '0; m_cnt = '0; m_idle = 1'b1; m_wait = 0;
        end else if (m_on) begin
            if (redirect) begin
                m_pc = redirect_pc & ~32'h3;
                m_valid = 1'b0;
                m_idle = !run;
                m_wait = run ? 2 : 0;
            end else if (m_valid) begin
                if (insn_ready) begin
                    m_pc = m_pc + 32'd4;
                    m_cnt = m_cnt + 32'd1;
                    m_valid = 1'b0;
                    m_idle = !run;
                    m_wait = run ? 2 : 0;
                end
            end else if (m_idle) begin
                if (run) begin
                    m_idle = 1'b0;
                    m_wait = 2;
                end
            end else if (m_wait > 0) begin
                m_wait = m_wait - 1;
                if (m_wait == 0) begin
                    m_valid = 1'b1;
                    m_insn = mem[m_pc[AW+1:2]];
                    m_pcout = m_pc;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (m_on) begin
            chk("cyc_valid", 32'(insn_valid), 32'(m_valid));
            chk("cyc_insn", insn_out, m_insn);
            chk("cyc_pc_out", pc_out, m_pcout);
            chk("cyc_count", fetch_count, m_cnt);
            chk("cyc_addr", 32'(inst_ram_address), 32'(m_pc[AW+1:2]));
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!insn_valid && n < 20) begin
            step();
            n++;
        end
        chk("valid_timeout", 32'(insn_valid), 32'd1);
    endtask

    int n;
    logic [31:0] hold_insn, hold_pc;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = {16'(i) ^ 16'hBEEF, 16'(i)};
        mem[0] = 32'h00100093;
        mem[1] = 32'h00208113;
        mem[2] = 32'h0000006F;

        // Reset and first three fetches
        step(); step();
        reset = 1'b0;
        chk("rst_valid", 32'(insn_valid), 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        wait_valid(n);
        chk("first_latency", 32'(n), 32'd3);
        chk("first_insn", insn_out, 32'h00100093);
        chk("first_pc", pc_out, 32'h0);
        step();
        wait_valid(n);
        chk("second_pc", pc_out, 32'h4);
        chk("second_insn", insn_out, 32'h00208113);
        step();
        wait_valid(n);
        chk("third_pc", pc_out, 32'h8);
        chk("third_insn", insn_out, 32'h0000006F);
        step();
        chk("count_after3", fetch_count, 32'd3);

        // Backpressure
        insn_ready = 1'b0;
        wait_valid(n);
        hold_insn = insn_out;
        hold_pc = pc_out;
        chk("bp_pc", pc_out, 32'hC);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_insn_hold", insn_out, hold_insn);
            chk("bp_pc_hold", pc_out, hold_pc);
            chk("bp_addr_hold", 32'(inst_ram_address), 32'h3);
        end
        insn_ready = 1'b1;
        step();
        chk("bp_count", fetch_count, 32'd4);
        chk("bp_valid_drop", 32'(insn_valid), 32'd0);
        step();
        chk("bp_single_hs", fetch_count, 32'd4);

        // Redirect while VALID with ready high
        insn_ready = 1'b0;
        wait_valid(n);
        insn_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h103;
        step();
        redirect = 1'b0;
        chk("rd_count", fetch_count, 32'd4);
        chk("rd_valid", 32'(insn_valid), 32'd0);
        chk("rd_addr", 32'(inst_ram_address), 32'h40);
        wait_valid(n);
        chk("rd_pc", pc_out, 32'h100);
        chk("rd_insn", insn_out, {16'h40 ^ 16'hBEEF, 16'h40});

        // run dropped during ISSUE
        step();
        run = 1'b0;
        step();
        step();
        chk("run_valid", 32'(insn_valid), 32'd1);
        chk("run_pc", pc_out, 32'h104);
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("run_idle_valid", 32'(insn_valid), 32'd0);
            chk("run_idle_count", fetch_count, 32'd6);
        end
        run = 1'b1;
        wait_valid(n);
        chk("run_resume_pc", pc_out, 32'h108);

        // Address wrap
        insn_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'hFFFFFFFC;
        step();
        redirect = 1'b0;
        chk("wrap_addr", 32'(inst_ram_address), 32'hFFFF);
        wait_valid(n);
        chk("wrap_pc", pc_out, 32'hFFFFFFFC);
        insn_ready = 1'b1;
        step();
        chk("wrap_addr0", 32'(inst_ram_address), 32'h0);
        wait_valid(n);
        chk("wrap_next_pc", pc_out, 32'h0);
        chk("wrap_next_insn", insn_out, 32'h00100093);

        // Reset asserted in FETCHED
        step();
        step();
        reset = 1'b1;
        step();
        chk("mid_rst_valid", 32'(insn_valid), 32'd0);
        chk("mid_rst_count", fetch_count, 32'd0);
        chk("mid_rst_insn", insn_out, 32'h0);
        chk("mid_rst_addr", 32'(inst_ram_address), 32'h0);
        reset = 1'b0;
        wait_valid(n);
        chk("mid_rst_latency", 32'(n), 32'd3);
        chk("mid_rst_pc", pc_out, 32'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
